cdm_mem_responder: RTL and testbench
====================================

// Module: cdm_mem_responder
// PURPOSE
// - Target side of the CDM16 core memory bus: answers mem_addr/mem_en/mem_write/mem_out, returns mem_in.
// - Word-addressed on-chip RAM with byte-lane writes, plus a small MMIO window at the top of the address space.
// - The MMIO window holds a byte TX FIFO drained over a valid/ready stream, a status register and a 32-bit cycle counter.
// - Instantiated next to the core wrapper in the FPGA top; same clock as the core.
// PARAMETERS
// - RAM_WORDS   16384  RAM depth in 16-bit words; power of 2, <= 32760 (must not overlap the MMIO window)
// - FIFO_DEPTH  8      TX FIFO entries; power of 2, >= 2
// - INIT_FILE   ""     $readmemh image for RAM; empty = no init
// PORTS
// - clock      in   1   single clock, rising edge
// - reset_n    in   1   asynchronous, active-low reset
// - mem_addr   in   15  word address from core (byte address [15:1])
// - mem_out    in   16  write data from core, already lane-aligned
// - mem_en     in   1   access strobe
// - mem_write  in   2   byte-lane write enables: [1]=bits 15:8, [0]=bits 7:0; 00 = read
// - mem_in     out  16  read data to core
// - tx_data    out  8   FIFO head byte
// - tx_valid   out  1   FIFO not empty
// - tx_ready   in   1   sink accepts tx_data when tx_valid & tx_ready at a rising edge
// BEHAVIOUR
// - Reset values: mem_in=0, tx_valid=0, tx_data=0, FIFO empty, overflow=0, cycle counter=0, hi_snap=0. RAM contents are not reset.
// - Map (word addr): 0..RAM_WORDS-1 RAM; 0x7FF8 TX_DATA; 0x7FF9 STATUS; 0x7FFA CYCLE_LO; 0x7FFB CYCLE_HI; all else unmapped.
// - Reads: mem_en=1, mem_write=00 sampled at edge N -> mem_in valid after edge N, held until the next read. Fixed 1-cycle latency, no wait states.
// - mem_in is updated only on reads. Writes and idle cycles hold the last value.
// - Unmapped reads return 0. Unmapped writes are ignored. TX_DATA reads return 0.
// - RAM write: each lane with mem_write bit set takes the matching mem_out byte at the edge; the other lane is unchanged.
// - RAM read-during-write of the same word cannot occur (a cycle is either a read or a write).
// - TX_DATA write with mem_write[0]=1 pushes mem_out[7:0]. Lane 1 alone is ignored.
//   - Push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
//   - Otherwise the byte is dropped and the sticky overflow bit is set.
// - STATUS read: {8'd0, count[3:0], 1'b0, overflow, empty, full}; count saturates display at 15.
// - STATUS write with mem_write[0]=1 and mem_out[2]=1 clears overflow.
//   - If a dropped push happens in the same cycle, set wins.
// - Pop: tx_valid & tx_ready at an edge removes the head. tx_data shows the new head, or holds the last value when empty.
// - Simultaneous push+pop: count unchanged. On an empty FIFO, the pushed byte becomes visible the cycle after the push (no bypass).
// - Pointers wrap modulo FIFO_DEPTH. A count register of width $clog2(FIFO_DEPTH)+1 separates full from empty.
// - Cycle counter: 32-bit, +1 every clock, wraps 0xFFFFFFFF -> 0.
//   - CYCLE_LO read returns bits [15:0] and latches bits [31:16] into hi_snap in the same edge.
//   - CYCLE_HI read returns hi_snap.
//   - Writes to either are ignored.
// - reset_n low mid-operation: FIFO flushed, in-flight read discarded, tx_valid drops immediately (async).
// - No FSM beyond the FIFO. The single pipeline stage is the registered read-select (RAM/MMIO mux registered with the address).
// STRUCTURE
// - Package cdm_mem_pkg holds:
//   - localparams MMIO_TX_DATA=15'h7FF8, MMIO_STATUS=15'h7FF9, MMIO_CYCLE_LO=15'h7FFA, MMIO_CYCLE_HI=15'h7FFB
//   - STATUS bit indices ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_CNT_LSB=4
//   - typedef enum {SEL_RAM, SEL_TX, SEL_STATUS, SEL_CLO, SEL_CHI, SEL_NONE} rd_sel_t
// - Sub-module cdm_byte_fifo (DEPTH param): push/pop/full/empty/count/head. Synchronous, async active-low reset.
// - RAM is an inferred BRAM: two byte-wide write enables, registered read.
// TESTING
// - Write 0x1234 to word 5 (mem_write=11), then read word 5 -> mem_in=0x1234 exactly one cycle after the read strobe.
// - Write 0xAB00 to word 5 with mem_write=10, then read -> 0xAB34. Write 0x00CD with mem_write=01, then read -> 0xABCD.
// - tx_ready=0, push 9 bytes 0x01..0x09 -> STATUS=0x0085 (count 8, full, overflow). Write STATUS 0x0004 -> STATUS=0x0081.
// - Then tx_ready=1 -> tx_data 0x01..0x08, one per cycle. tx_valid falls after 0x08 and STATUS reads 0x0002.
// - Force cycle counter to 0x0001FFFF: read CYCLE_LO -> 0xFFFF, then CYCLE_HI -> 0x0001, even though the counter has rolled to 0x0002xxxx.
// - Push 3 bytes, assert reset_n=0 mid-burst with tx_ready=1 -> tx_valid=0 and mem_in=0 immediately. After release, STATUS=0x0002 and RAM word 5 still reads 0xABCD.

Source files
------------

// File: rtl/cdm_mem_pkg.sv
// Shared definitions for the CDM16 memory responder: MMIO map, STATUS bit layout
// and the registered read-select encoding.
package cdm_mem_pkg;

  localparam logic [14:0] MMIO_TX_DATA  = 15'h7FF8;
  localparam logic [14:0] MMIO_STATUS   = 15'h7FF9;
  localparam logic [14:0] MMIO_CYCLE_LO = 15'h7FFA;
  localparam logic [14:0] MMIO_CYCLE_HI = 15'h7FFB;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TX,
    SEL_STATUS,
    SEL_CLO,
    SEL_CHI,
    SEL_NONE
  } rd_sel_t;

  // RAM occupies the bottom of the space; everything else but the MMIO words is unmapped.
  function automatic rd_sel_t decode_sel(input logic [14:0] addr, input logic [14:0] ram_words);
    rd_sel_t sel;
    sel = SEL_NONE;
    if (addr < ram_words) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        MMIO_TX_DATA:  sel = SEL_TX;
        MMIO_STATUS:   sel = SEL_STATUS;
        MMIO_CYCLE_LO: sel = SEL_CLO;
        MMIO_CYCLE_HI: sel = SEL_CHI;
        default:       sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/cdm_byte_fifo.sv
// Byte FIFO with registered head output; a push into an empty FIFO shows up on
// head one cycle later, and head holds its last value once the FIFO drains.
module cdm_byte_fifo #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          dropped,
  output logic [CW-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          pop_ok, push_ok;
  logic [CW-1:0] after_pop;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop_ok);
    dropped   = push & ~push_ok;
    count_d   = count_q + CW'(push_ok) - CW'(pop_ok);
    after_pop = count_q - CW'(pop_ok);
    wr_ptr_d  = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    head_d    = head_q;
    // The new head slot is being written this very edge, so take the byte directly.
    if (push_ok && after_pop == '0) begin
      head_d = push_data;
    end else if (count_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/cdm_mem_responder.sv
// CDM16 memory bus target: byte-lane RAM plus an MMIO window with a TX byte FIFO,
// status register and free-running cycle counter. All reads have a fixed 1-cycle latency.
module cdm_mem_responder
  import cdm_mem_pkg::*;
#(
  parameter int    RAM_WORDS  = 16384,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [14:0] mem_addr,
  input  logic [15:0] mem_out,
  input  logic        mem_en,
  input  logic [1:0]  mem_write,
  output logic [15:0] mem_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [14:0] RAM_LIMIT = 15'(RAM_WORDS);

  logic [15:0]   ram_q [RAM_WORDS];
  logic [15:0]   ram_rd_q;
  logic [AW-1:0] ram_idx;

  rd_sel_t       sel, rd_sel_q, rd_sel_d;
  logic [15:0]   mmio_rd_q, mmio_rd_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [15:0]   hi_snap_q, hi_snap_d;
  logic          ovf_q, ovf_d;

  logic          rd_en, wr_en, push, ovf_clr;
  logic [1:0]    ram_we;
  logic [15:0]   status;
  logic [31:0]   cnt_ext;
  logic [3:0]    cnt_disp;

  logic          fifo_full, fifo_empty, fifo_dropped;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;

  always_comb begin
    rd_en    = mem_en & (mem_write == 2'b00);
    wr_en    = mem_en & (mem_write != 2'b00);
    sel      = decode_sel(mem_addr, RAM_LIMIT);
    ram_idx  = mem_addr[AW-1:0];
    ram_we   = (wr_en && sel == SEL_RAM) ? mem_write : 2'b00;
    push     = wr_en & mem_write[0] & (sel == SEL_TX);
    ovf_clr  = wr_en & mem_write[0] & mem_out[ST_OVF] & (sel == SEL_STATUS);

    cnt_ext  = 32'(fifo_count);
    cnt_disp = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
    status   = '0;
    status[ST_FULL]           = fifo_full;
    status[ST_EMPTY]          = fifo_empty;
    status[ST_OVF]            = ovf_q;
    status[ST_CNT_LSB +: 4]   = cnt_disp;

    // A dropped push in the same cycle as a clear leaves overflow set.
    ovf_d = ovf_q;
    if (ovf_clr)      ovf_d = 1'b0;
    if (fifo_dropped) ovf_d = 1'b1;

    cyc_d     = cyc_q + 32'd1;
    hi_snap_d = (rd_en && sel == SEL_CLO) ? cyc_q[31:16] : hi_snap_q;

    rd_sel_d  = rd_en ? sel : rd_sel_q;
    mmio_rd_d = mmio_rd_q;
    if (rd_en) begin
      case (sel)
        SEL_STATUS: mmio_rd_d = status;
        SEL_CLO:    mmio_rd_d = cyc_q[15:0];
        SEL_CHI:    mmio_rd_d = hi_snap_q;
        default:    mmio_rd_d = '0;
      endcase
    end
  end

  // Inferred block RAM: two byte write enables, registered read port.
  always_ff @(posedge clock) begin
    if (ram_we[0]) ram_q[ram_idx][7:0]  <= mem_out[7:0];
    if (ram_we[1]) ram_q[ram_idx][15:8] <= mem_out[15:8];
    if (rd_en && sel == SEL_RAM) ram_rd_q <= ram_q[ram_idx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel_q  <= SEL_NONE;
      mmio_rd_q <= '0;
      cyc_q     <= '0;
      hi_snap_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rd_sel_q  <= rd_sel_d;
      mmio_rd_q <= mmio_rd_d;
      cyc_q     <= cyc_d;
      hi_snap_q <= hi_snap_d;
      ovf_q     <= ovf_d;
    end
  end

  cdm_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clock),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (mem_out[7:0]),
    .pop       (tx_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign mem_in   = (rd_sel_q == SEL_RAM) ? ram_rd_q : mmio_rd_q;
  assign tx_data  = fifo_head;
  assign tx_valid = ~fifo_empty;

endmodule

// File: tb/tb_cdm_mem_responder.sv
// Self-checking bench for cdm_mem_responder: directed scenarios plus a randomized
// mix of bus accesses and stream back-pressure checked against a queue-based model.
module tb_cdm_mem_responder;

  localparam int          D         = 8;
  localparam int          RAM_WORDS = 16384;
  localparam logic [14:0] A_TX      = 15'h7FF8;
  localparam logic [14:0] A_STATUS  = 15'h7FF9;
  localparam logic [14:0] A_CLO     = 15'h7FFA;
  localparam logic [14:0] A_CHI     = 15'h7FFB;

  logic        clock;
  logic        reset_n;
  logic [14:0] mem_addr;
  logic [15:0] mem_out;
  logic        mem_en;
  logic [1:0]  mem_write;
  logic [15:0] mem_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  fifo_m[$];
  logic [15:0] ram_m[int];
  logic        ovf_m;
  logic [7:0]  tx_last_m;
  logic [31:0] model_cyc;

  cdm_mem_responder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem_addr  (mem_addr),
    .mem_out   (mem_out),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .mem_in    (mem_in),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference cycle count: clock edges seen since reset was released.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_cyc <= 32'd0;
    else          model_cyc <= model_cyc + 32'd1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [15:0] status_of(input int cnt, input logic ovf);
    int disp;
    disp = (cnt > 15) ? 15 : cnt;
    return 16'(disp * 16 + (ovf ? 4 : 0) + (cnt == 0 ? 2 : 0) + (cnt == D ? 1 : 0));
  endfunction

  function automatic logic [14:0] pick_addr(input int i);
    case (i)
      0: return 15'h0000;
      1: return 15'h0001;
      2: return 15'h0002;
      3: return 15'h0003;
      4: return 15'h0007;
      5: return 15'h3FFF;
      6: return 15'h4000;
      7: return 15'h5A5A;
      8: return 15'h7FF7;
      9: return 15'h7FFC;
      default: return 15'h7FFF;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_read(input logic [14:0] a, output logic [15:0] d);
    mem_en = 1'b1; mem_write = 2'b00; mem_addr = a;
    @(posedge clock); #1;
    d = mem_in;
    mem_en = 1'b0;
  endtask

  task automatic bus_write(input logic [14:0] a, input logic [15:0] d, input logic [1:0] we);
    mem_en = 1'b1; mem_write = we; mem_addr = a; mem_out = d;
    @(posedge clock); #1;
    mem_en = 1'b0; mem_write = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] got;
    logic [31:0] c;
    reset_n = 1'b0; tx_ready = 1'b0; mem_en = 1'b0; mem_write = 2'b00;
    mem_addr = '0; mem_out = '0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (mem_in !== 16'h0000) begin n_err++; $display("FAIL rst_mem_in: got %h want 0000", mem_in); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== 16'h0002) begin n_err++; $display("FAIL rst_status: got %h want 0002", got); end
    c = model_cyc;
    bus_read(A_CLO, got);
    n_cmp++; if (got !== c[15:0]) begin n_err++; $display("FAIL rst_cycle_lo: got %h want %h", got, c[15:0]); end
    bus_read(A_CHI, got);
    n_cmp++; if (got !== 16'h0000) begin n_err++; $display("FAIL rst_cycle_hi: got %h want 0000", got); end
  endtask

  task automatic test_ram_lanes();
    logic [15:0] got;
    bus_read(15'h5000, got);
    n_cmp++; if (got !== 16'h0000) begin n_err++; $display("FAIL unmapped_read: got %h want 0000", got); end
    bus_write(15'd5, 16'h1234, 2'b11);
    n_cmp++; if (mem_in !== 16'h0000) begin n_err++; $display("FAIL write_holds_mem_in: got %h want 0000", mem_in); end
    mem_en = 1'b1; mem_write = 2'b00; mem_addr = 15'd5;
    #3;
    n_cmp++; if (mem_in !== 16'h0000) begin n_err++; $display("FAIL read_latency_early: got %h want 0000", mem_in); end
    @(posedge clock); #1;
    mem_en = 1'b0;
    n_cmp++; if (mem_in !== 16'h1234) begin n_err++; $display("FAIL ram_full_word: got %h want 1234", mem_in); end
    bus_write(15'd5, 16'hAB00, 2'b10);
    bus_read(15'd5, got);
    n_cmp++; if (got !== 16'hAB34) begin n_err++; $display("FAIL ram_lane_hi: got %h want AB34", got); end
    bus_write(15'd5, 16'h00CD, 2'b01);
    bus_read(15'd5, got);
    n_cmp++; if (got !== 16'hABCD) begin n_err++; $display("FAIL ram_lane_lo: got %h want ABCD", got); end
    bus_write(15'h4000, 16'hFFFF, 2'b11);
    bus_read(15'h4000, got);
    n_cmp++; if (got !== 16'h0000) begin n_err++; $display("FAIL unmapped_write: got %h want 0000", got); end
  endtask

  task automatic test_fifo_overflow();
    logic [15:0] got;
    tx_ready = 1'b0;
    bus_write(A_TX, 16'h00FF, 2'b10);
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== 16'h0002) begin n_err++; $display("FAIL tx_lane1_ignored: got %h want 0002", got); end
    for (int i = 1; i <= 9; i++) bus_write(A_TX, {8'hEE, 8'(i)}, 2'b01);
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== 16'h0085) begin n_err++; $display("FAIL status_full_ovf: got %h want 0085", got); end
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      n_err++; $display("FAIL head_while_full: got v=%b d=%h want v=1 d=01", tx_valid, tx_data);
    end
    bus_read(A_TX, got);
    n_cmp++; if (got !== 16'h0000) begin n_err++; $display("FAIL tx_data_read: got %h want 0000", got); end
    bus_write(A_STATUS, 16'h0003, 2'b01);
    bus_write(A_STATUS, 16'h0004, 2'b10);
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== 16'h0085) begin n_err++; $display("FAIL ovf_no_clear: got %h want 0085", got); end
    bus_write(A_STATUS, 16'h0004, 2'b01);
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== 16'h0081) begin n_err++; $display("FAIL ovf_clear: got %h want 0081", got); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        n_err++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(i));
      end
      @(posedge clock); #1;
    end
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h08) begin
      n_err++; $display("FAIL drain_end: got v=%b d=%h want v=0 d=08", tx_valid, tx_data);
    end
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== 16'h0002) begin n_err++; $display("FAIL status_after_drain: got %h want 0002", got); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(A_TX, 16'(8'h10 + 8'(i)), 2'b01);
    tx_ready = 1'b1;
    bus_write(A_TX, 16'h0018, 2'b01);
    tx_ready = 1'b0;
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== 16'h0081) begin n_err++; $display("FAIL push_pop_full: got %h want 0081", got); end
    n_cmp++; if (tx_data !== 8'h11) begin n_err++; $display("FAIL push_pop_head: got %h want 11", tx_data); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h11 + 8'(i)) begin
        n_err++; $display("FAIL b2b_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'h11 + 8'(i));
      end
      @(posedge clock); #1;
    end
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got v=%b want 0", tx_valid); end
  endtask

  task automatic test_random();
    logic [15:0] got, d, e, held, w;
    logic [14:0] a;
    logic [1:0]  we;
    logic        rdy, pop, push_try, is_rd;
    int          op, pre;
    fifo_m.delete();
    ovf_m = 1'b0;
    tx_last_m = 8'h18;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      bus_write(pick_addr(i), d, 2'b11);
      ram_m[int'(pick_addr(i))] = d;
    end
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== status_of(0, 1'b0)) begin n_err++; $display("FAIL rand_start_status: got %h want 0002", got); end
    held = status_of(0, 1'b0);
    for (int it = 0; it < 400; it++) begin
      rdy = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 6);
      a   = pick_addr($urandom_range(0, 10));
      d   = 16'($urandom);
      we  = 2'($urandom_range(1, 3));
      is_rd = 1'b0; push_try = 1'b0; e = '0;
      pop = rdy && (fifo_m.size() > 0);
      case (op)
        0: begin is_rd = 1'b1; e = (int'(a) < RAM_WORDS) ? ram_m[int'(a)] : 16'h0000; end
        2: begin a = A_TX; push_try = we[0]; end
        3: begin a = A_STATUS; is_rd = 1'b1; e = status_of(fifo_m.size(), ovf_m); end
        4: begin a = A_TX; is_rd = 1'b1; e = 16'h0000; end
        6: a = A_STATUS;
        default: ;
      endcase
      tx_ready = rdy;
      mem_en = (op != 5); mem_addr = a; mem_out = d; mem_write = is_rd ? 2'b00 : we;
      @(posedge clock); #1;
      mem_en = 1'b0; mem_write = 2'b00;
      if (op == 1 && int'(a) < RAM_WORDS) begin
        w = ram_m[int'(a)];
        if (we[0]) w[7:0]  = d[7:0];
        if (we[1]) w[15:8] = d[15:8];
        ram_m[int'(a)] = w;
      end
      if (op == 6 && we[0] && d[2]) ovf_m = 1'b0;
      pre = fifo_m.size();
      if (pop) void'(fifo_m.pop_front());
      if (push_try) begin
        if (pre < D || pop) fifo_m.push_back(d[7:0]);
        else ovf_m = 1'b1;
      end
      if (fifo_m.size() > 0) tx_last_m = fifo_m[0];
      if (is_rd) exp_q.push_back(e);
      if (is_rd) held = exp_q.pop_front();
      n_cmp++; if (mem_in !== held) begin n_err++; $display("FAIL rand_mem_in it=%0d op=%0d: got %h want %h", it, op, mem_in, held); end
      n_cmp++; if (tx_valid !== (fifo_m.size() > 0) || tx_data !== tx_last_m) begin
        n_err++; $display("FAIL rand_tx it=%0d: got v=%b d=%h want v=%b d=%h", it, tx_valid, tx_data, fifo_m.size() > 0, tx_last_m);
      end
    end
    tx_ready = 1'b1;
    repeat (D + 1) @(posedge clock);
    #1;
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rand_drain: got v=%b want 0", tx_valid); end
  endtask

  task automatic test_cycle_counter();
    logic [15:0] got;
    logic [31:0] c;
    int guard;
    guard = 0;
    while (model_cyc != 32'h0000_FFFF && guard < 80000) begin
      @(posedge clock); #1;
      guard++;
    end
    n_cmp++; if (model_cyc != 32'h0000_FFFF) begin n_err++; $display("FAIL cycle_wait: budget expired at %h", model_cyc); end
    bus_read(A_CLO, got);
    n_cmp++; if (got !== 16'hFFFF) begin n_err++; $display("FAIL cycle_lo_top: got %h want FFFF", got); end
    bus_read(A_CHI, got);
    n_cmp++; if (got !== 16'h0000) begin n_err++; $display("FAIL cycle_hi_snap: got %h want 0000", got); end
    bus_write(A_CHI, 16'hFFFF, 2'b11);
    bus_write(A_CLO, 16'hFFFF, 2'b11);
    c = model_cyc;
    bus_read(A_CLO, got);
    n_cmp++; if (got !== c[15:0]) begin n_err++; $display("FAIL cycle_lo_after_wrap: got %h want %h", got, c[15:0]); end
    repeat (5) @(posedge clock);
    #1;
    bus_read(A_CHI, got);
    n_cmp++; if (got !== c[31:16]) begin n_err++; $display("FAIL cycle_hi_after_wrap: got %h want %h", got, c[31:16]); end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] got;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(A_TX, 16'(8'h21 + 8'(i)), 2'b01);
    bus_read(15'd5, got);
    n_cmp++; if (got !== 16'hABCD) begin n_err++; $display("FAIL pre_reset_read: got %h want ABCD", got); end
    tx_ready = 1'b1;
    mem_en = 1'b1; mem_write = 2'b00; mem_addr = 15'd5;
    n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid: got %b want 1", tx_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || mem_in !== 16'h0000) begin
      n_err++; $display("FAIL async_reset: got v=%b mem_in=%h want v=0 mem_in=0000", tx_valid, mem_in);
    end
    @(posedge clock); #1;
    mem_en = 1'b0; tx_ready = 1'b0;
    n_cmp++; if (mem_in !== 16'h0000) begin n_err++; $display("FAIL inflight_discard: got %h want 0000", mem_in); end
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_err++; $display("FAIL post_reset_tx: got v=%b d=%h want v=0 d=00", tx_valid, tx_data);
    end
    bus_read(A_STATUS, got);
    n_cmp++; if (got !== 16'h0002) begin n_err++; $display("FAIL post_reset_status: got %h want 0002", got); end
    bus_read(15'd5, got);
    n_cmp++; if (got !== 16'hABCD) begin n_err++; $display("FAIL ram_survives_reset: got %h want ABCD", got); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_ram_lanes();
    test_fifo_overflow();
    test_back_to_back();
    test_random();
    test_cycle_counter();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
